// File: rtl/oscill_key_emu.sv
// Front-panel key-press emulator: turns a host command into a push-button-shaped press on one key line.
// Optional contact chatter on press/release is compiled in with KEY_EMU_BOUNCE_EN.
module oscill_key_emu #(
  parameter int HOLD_CYC   = 500_000,
  parameter int GAP_CYC    = 500_000,
  parameter int BOUNCE_CYC = 1_000,
  parameter int BOUNCE_N   = 4,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_key,
  output logic       cmd_ready,
  output logic [3:0] key_out,
  output logic       key_5_out,
  output logic       done,
  output logic       cmd_err
);

  typedef enum logic [2:0] {IDLE, P_BOUNCE, HOLD, R_BOUNCE, GAP, DONE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  // Reject parameter sets that would break the press shape at elaboration time.
  generate
    if (HOLD_CYC < 1 || GAP_CYC < 1 || BOUNCE_CYC < 1 || BOUNCE_N < 2 || (BOUNCE_N % 2) != 0 || CNT_W < 2) begin : g_param_check
      $error("oscill_key_emu: illegal parameter combination");
    end
  endgenerate

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       key_out_reg;
  logic             key_5_reg;
  logic             done_reg;
  logic             cmd_err_reg;

`ifdef KEY_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SEG_LAST    = CNT_W'(BOUNCE_N - 1);
  logic [CNT_W-1:0] seg_reg;
  logic [2:0]       key_reg;
`endif

  function automatic logic [3:0] drive_lines(input logic [2:0] code, input logic on);
    logic [3:0] l;
    l = 4'b1111;
    if (on) begin
      case (code)
        3'd1:    l[0] = 1'b0;
        3'd2:    l[1] = 1'b0;
        3'd3:    l[2] = 1'b0;
        3'd4:    l[3] = 1'b0;
        default: l = 4'b1111;
      endcase
    end
    return l;
  endfunction

  function automatic logic code_ok(input logic [2:0] code);
    return (code >= 3'd1) && (code <= 3'd5);
  endfunction

  assign cmd_ready = (state_reg == IDLE);
  assign key_out   = key_out_reg;
  assign key_5_out = key_5_reg;
  assign done      = done_reg;
  assign cmd_err   = cmd_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      key_out_reg <= 4'b1111;
      key_5_reg   <= 1'b0;
      done_reg    <= 1'b0;
      cmd_err_reg <= 1'b0;
`ifdef KEY_EMU_BOUNCE_EN
      seg_reg     <= '0;
      key_reg     <= '0;
`endif
    end else begin
      done_reg    <= 1'b0;
      cmd_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (cmd_valid) begin
            if (code_ok(cmd_key)) begin
              key_out_reg <= drive_lines(cmd_key, 1'b1);
              key_5_reg   <= (cmd_key == 3'd5);
`ifdef KEY_EMU_BOUNCE_EN
              key_reg     <= cmd_key;
              seg_reg     <= '0;
              state_reg   <= (cmd_key == 3'd5) ? HOLD : P_BOUNCE;
`else
              state_reg   <= HOLD;
`endif
            end else begin
              // Invalid codes complete immediately without touching the lines.
              state_reg   <= DONE;
              done_reg    <= 1'b1;
              cmd_err_reg <= 1'b1;
            end
          end
        end
`ifdef KEY_EMU_BOUNCE_EN
        P_BOUNCE: begin
          if (cnt_reg == BOUNCE_LAST) begin
            cnt_reg <= '0;
            if (seg_reg == SEG_LAST) begin
              state_reg   <= HOLD;
              key_out_reg <= drive_lines(key_reg, 1'b1);
            end else begin
              // Next segment is pressed when it is even, i.e. when the current one is odd.
              seg_reg     <= seg_reg + 1'b1;
              key_out_reg <= drive_lines(key_reg, seg_reg[0]);
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        R_BOUNCE: begin
          if (cnt_reg == BOUNCE_LAST) begin
            cnt_reg <= '0;
            if (seg_reg == SEG_LAST) begin
              state_reg   <= GAP;
              key_out_reg <= 4'b1111;
            end else begin
              seg_reg     <= seg_reg + 1'b1;
              key_out_reg <= drive_lines(key_reg, ~seg_reg[0]);
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            cnt_reg     <= '0;
            key_out_reg <= 4'b1111;
            key_5_reg   <= 1'b0;
`ifdef KEY_EMU_BOUNCE_EN
            seg_reg     <= '0;
            state_reg   <= (key_reg == 3'd5) ? GAP : R_BOUNCE;
`else
            state_reg   <= GAP;
`endif
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: begin
          cnt_reg     <= '0;
          key_out_reg <= 4'b1111;
          key_5_reg   <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oscill_key_emu.sv
// Directed bench for oscill_key_emu: a per-cycle expected-output scoreboard is filled at each accept and drained cycle by cycle.
// Honours KEY_EMU_BOUNCE_EN in its model so it matches either build of the design.
module tb_oscill_key_emu;

  localparam int HOLD = 20;
  localparam int GAP  = 10;
  localparam int BCYC = 3;
  localparam int BN   = 4;

  typedef struct packed {
    logic [3:0] key;
    logic       k5;
    logic       dn;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_key = 3'd0;
  logic       cmd_ready;
  logic [3:0] key_out;
  logic       key_5_out;
  logic       done;
  logic       cmd_err;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  oscill_key_emu #(
    .HOLD_CYC  (HOLD),
    .GAP_CYC   (GAP),
    .BOUNCE_CYC(BCYC),
    .BOUNCE_N  (BN),
    .CNT_W     (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_key  (cmd_key),
    .cmd_ready(cmd_ready),
    .key_out  (key_out),
    .key_5_out(key_5_out),
    .done     (done),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build the expected per-cycle outputs for cycles 1..end of one command.
  task automatic push_expect(input logic [2:0] code);
    exp_t act, idl, dn;
    idl = '{key: 4'b1111, k5: 1'b0, dn: 1'b0, err: 1'b0};
    if (code == 3'd0 || code > 3'd5) begin
      q.push_back('{key: 4'b1111, k5: 1'b0, dn: 1'b1, err: 1'b1});
      return;
    end
    act = idl;
    if (code == 3'd5) act.k5 = 1'b1;
    else act.key[code - 3'd1] = 1'b0;
    dn = '{key: 4'b1111, k5: 1'b0, dn: 1'b1, err: 1'b0};
`ifdef KEY_EMU_BOUNCE_EN
    if (code != 3'd5)
      for (int s = 0; s < BN; s++)
        for (int c = 0; c < BCYC; c++) q.push_back((s % 2 == 0) ? act : idl);
`endif
    for (int i = 0; i < HOLD; i++) q.push_back(act);
`ifdef KEY_EMU_BOUNCE_EN
    if (code != 3'd5)
      for (int s = 0; s < BN; s++)
        for (int c = 0; c < BCYC; c++) q.push_back((s % 2 == 0) ? idl : act);
`endif
    for (int i = 0; i < GAP; i++) q.push_back(idl);
    q.push_back(dn);
  endtask

  // Called at a negedge; returns just after the accept edge (cycle 0).
  task automatic press_start(input logic [2:0] code, input bit keep);
    cmd_valid = 1'b1;
    cmd_key   = code;
    chk("ready_before_accept", {7'd0, cmd_ready}, 8'd1);
    push_expect(code);
    @(posedge clk);
    if (!keep) begin
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = q.pop_front();
      chk("key_out",   {4'd0, key_out},   {4'd0, e.key});
      chk("key_5_out", {7'd0, key_5_out}, {7'd0, e.k5});
      chk("done",      {7'd0, done},      {7'd0, e.dn});
      chk("cmd_err",   {7'd0, cmd_err},   {7'd0, e.err});
      chk("cmd_ready_busy", {7'd0, cmd_ready}, 8'd0);
    end
  endtask

  task automatic press(input logic [2:0] code, input bit keep);
    int n;
    press_start(code, keep);
    n = q.size();
    run_cycles(n);
    @(negedge clk);
    chk("ready_after_done", {7'd0, cmd_ready}, 8'd1);
    $display("cmd key=%0d cycles=%0d checks=%0d errors=%0d", code, n, checks, errors);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_key_out",   {4'd0, key_out},   8'h0f);
    chk("rst_key_5_out", {7'd0, key_5_out}, 8'd0);
    chk("rst_done",      {7'd0, done},      8'd0);
    chk("rst_cmd_err",   {7'd0, cmd_err},   8'd0);
    chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    rst_n = 1'b1;

    press(3'd2, 1'b0);
    press(3'd5, 1'b0);
    press(3'd0, 1'b0);
    press(3'd7, 1'b0);
    press(3'd6, 1'b0);

    // cmd_valid held across a whole press: only one accept, the next right after done.
    press(3'd3, 1'b1);
    press(3'd3, 1'b0);

    // Reset in the middle of HOLD aborts the press with no done pulse.
    press_start(3'd3, 1'b0);
    run_cycles(10);
    rst_n = 1'b0;
    #1;
    chk("abort_key_out",   {4'd0, key_out},   8'h0f);
    chk("abort_key_5_out", {7'd0, key_5_out}, 8'd0);
    chk("abort_done",      {7'd0, done},      8'd0);
    chk("abort_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("abort_hold_done", {7'd0, done},    8'd0);
      chk("abort_hold_key",  {4'd0, key_out}, 8'h0f);
    end
    rst_n = 1'b1;
    $display("cmd key=3 aborted by reset checks=%0d errors=%0d", checks, errors);

    press(3'd4, 1'b0);
    press(3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
